// File: rtl/generic_sram_arbiter.sv
// Round-robin arbiter sharing both ports of a dual-port SRAM among nreq requesters.
// Optional zero-fill of the whole SRAM after reset when GENERIC_SRAM_ARB_INIT_EN is defined.
module generic_sram_arbiter #(
    parameter int abits = 10,
    parameter int dbits = 16,
    parameter int nreq  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [nreq-1:0]       req_valid,
    output logic [nreq-1:0]       req_ready,
    input  logic [nreq-1:0]       req_we,
    input  logic [nreq*abits-1:0] req_addr,
    input  logic [nreq*dbits-1:0] req_wdata,
    output logic [nreq-1:0]       rsp_valid,
    output logic [nreq*dbits-1:0] rsp_rdata,
    output logic [abits-1:0]      a0,
    output logic [abits-1:0]      a1,
    output logic [dbits-1:0]      d0,
    output logic [dbits-1:0]      d1,
    output logic                  we0,
    output logic                  we1,
    input  logic [dbits-1:0]      q0,
    input  logic [dbits-1:0]      q1
);

    localparam int pbits = $clog2(nreq);

    logic [abits-1:0] addr_arr  [nreq];
    logic [dbits-1:0] wdata_arr [nreq];

    logic [pbits-1:0] ptr_reg, ptr_next;
    logic [nreq-1:0]  rsp_pend_reg, rsp_pend_next;
    logic [nreq-1:0]  rsp_port_reg, rsp_port_next;

    logic             g0_found, g1_found, conflict;
    logic [pbits-1:0] g0_idx, g1_idx;
    logic             grant0, grant1;
    logic             arb_en;
    logic             init_we;
    logic [abits-2:0] init_cnt;

    generate
        for (genvar gi = 0; gi < nreq; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*abits +: abits];
            assign wdata_arr[gi] = req_wdata[gi*dbits +: dbits];
        end
    endgenerate

`ifdef GENERIC_SRAM_ARB_INIT_EN
    typedef enum logic {
        S_INIT,
        S_ARB
    } state_t;

    state_t           state_reg, state_next;
    logic [abits-2:0] init_cnt_reg, init_cnt_next;
    logic             init_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_INIT;
            init_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
        end
    end

    // Each init cycle clears one even/odd word pair; leave after the last pair.
    always_comb begin
        state_next    = state_reg;
        init_cnt_next = init_cnt_reg;
        init_active   = 1'b0;
        case (state_reg)
            S_INIT: begin
                init_active   = 1'b1;
                init_cnt_next = init_cnt_reg + 1'b1;
                if (&init_cnt_reg) begin
                    state_next = S_ARB;
                end
            end
            default: begin
                init_active = 1'b0;
            end
        endcase
    end

    assign init_we  = init_active & ~rst;
    assign init_cnt = init_cnt_reg;
    assign arb_en   = ~rst & ~init_active;
`else
    assign init_we  = 1'b0;
    assign init_cnt = '0;
    assign arb_en   = ~rst;
`endif

    // Scan from ptr: first valid takes port 0, the next valid is the port 1 candidate.
    always_comb begin
        logic [pbits:0] sum;
        logic [pbits-1:0] idx;
        g0_found = 1'b0;
        g1_found = 1'b0;
        g0_idx   = '0;
        g1_idx   = '0;
        sum      = '0;
        idx      = '0;
        for (int k = 0; k < nreq; k++) begin
            sum = {1'b0, ptr_reg} + (pbits+1)'(k);
            if (sum >= (pbits+1)'(nreq)) begin
                sum = sum - (pbits+1)'(nreq);
            end
            idx = sum[pbits-1:0];
            if (req_valid[idx]) begin
                if (!g0_found) begin
                    g0_found = 1'b1;
                    g0_idx   = idx;
                end else if (!g1_found) begin
                    g1_found = 1'b1;
                    g1_idx   = idx;
                end
            end
        end
    end

    // Same-address pairs are only safe when both are reads.
    assign conflict = (addr_arr[g1_idx] == addr_arr[g0_idx]) &&
                      (req_we[g0_idx] || req_we[g1_idx]);
    assign grant0   = arb_en & g0_found;
    assign grant1   = arb_en & g1_found & ~conflict;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < nreq; i++) begin
            if ((grant0 && g0_idx == pbits'(i)) || (grant1 && g1_idx == pbits'(i))) begin
                req_ready[i] = 1'b1;
            end
        end
    end

    always_comb begin
        a0  = '0;
        a1  = '0;
        d0  = '0;
        d1  = '0;
        we0 = 1'b0;
        we1 = 1'b0;
        if (init_we) begin
            a0  = {init_cnt, 1'b0};
            a1  = {init_cnt, 1'b1};
            we0 = 1'b1;
            we1 = 1'b1;
        end else begin
            if (grant0) begin
                a0  = addr_arr[g0_idx];
                d0  = wdata_arr[g0_idx];
                we0 = req_we[g0_idx];
            end
            if (grant1) begin
                a1  = addr_arr[g1_idx];
                d1  = wdata_arr[g1_idx];
                we1 = req_we[g1_idx];
            end
        end
    end

    function automatic logic [pbits-1:0] wrap_inc(input logic [pbits-1:0] v);
        return (v == pbits'(nreq - 1)) ? '0 : v + 1'b1;
    endfunction

    always_comb begin
        ptr_next      = ptr_reg;
        rsp_pend_next = '0;
        rsp_port_next = '0;
        if (grant1) begin
            ptr_next = wrap_inc(g1_idx);
        end else if (grant0) begin
            ptr_next = wrap_inc(g0_idx);
        end
        if (grant0 && !req_we[g0_idx]) begin
            rsp_pend_next[g0_idx] = 1'b1;
            rsp_port_next[g0_idx] = 1'b0;
        end
        if (grant1 && !req_we[g1_idx]) begin
            rsp_pend_next[g1_idx] = 1'b1;
            rsp_port_next[g1_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg      <= '0;
            rsp_pend_reg <= '0;
            rsp_port_reg <= '0;
        end else begin
            ptr_reg      <= ptr_next;
            rsp_pend_reg <= rsp_pend_next;
            rsp_port_reg <= rsp_port_next;
        end
    end

    // Responses come straight from the SRAM's registered outputs; masked while in reset.
    assign rsp_valid = rsp_pend_reg & {nreq{~rst}};

    generate
        for (genvar gi = 0; gi < nreq; gi++) begin : g_rsp
            assign rsp_rdata[gi*dbits +: dbits] = !rsp_valid[gi] ? '0 :
                                                  (rsp_port_reg[gi] ? q1 : q0);
        end
    endgenerate

endmodule
